// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer/size encodings, master-side address-phase bundle,
// RAM-slave FSM states and the lane helpers used by the slave.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  // Master-side view of one address phase.
  typedef struct packed {
    logic [31:0] haddr;
    htrans_e     htrans;
    logic        hwrite;
    logic [2:0]  hsize;
  } ahb_addr_phase_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } slv_state_e;

  function automatic logic xfer_legal(input logic [2:0] size, input logic [1:0] a);
    case (size)
      HSIZE_BYTE: return 1'b1;
      HSIZE_HALF: return ~a[0];
      HSIZE_WORD: return a == 2'b00;
      default:    return 1'b0;
    endcase
  endfunction

  // Little-endian byte lanes touched by an aligned transfer.
  function automatic logic [3:0] lane_en(input logic [2:0] size, input logic [1:0] a);
    case (size)
      HSIZE_BYTE: return 4'b0001 << a;
      HSIZE_HALF: return a[1] ? 4'b1100 : 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/ahb_ram_byte_en.sv
// Word-wide RAM with per-byte write enables (written on clk) and a combinational read port.
// Contents are never reset.
module ahb_ram_byte_en #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [WORD_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [WORD_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [0:(1<<WORD_W)-1];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ahb_ram_slave.sv
// AHB-Lite RAM slave: WAIT_STATES low-HREADYOUT cycles then one completion cycle per OKAY
// transfer, two-cycle ERROR for misaligned/oversized transfers; back-to-back transfers pipeline.
module ahb_ram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int WORD_W = ADDR_W - 2;

  slv_state_e        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [2:0]        size_q, size_d;
  logic              xfer_q, xfer_d;
  logic              hreadyout_q, hreadyout_d;
  logic              hresp_q, hresp_d;
  logic [31:0]       hrdata_q, hrdata_d;

  logic              accept;
  logic              legal;
  logic              commit;
  logic [3:0]        wr_be;
  logic [WORD_W-1:0] rd_idx;
  logic [31:0]       rd_word;
  logic [31:0]       fwd_word;
  logic              unused_addr_hi;

  assign accept = HSEL & HREADY & HTRANS[1];
  assign legal  = xfer_legal(HSIZE, HADDR[1:0]);

  // xfer_q marks the completion cycle of a legal transfer; a write lands on the edge ending it.
  assign commit = (state_q == ST_IDLE) & xfer_q & write_q & ~reset;
  assign wr_be  = commit ? lane_en(size_q, addr_q[1:0]) : 4'b0000;

  assign rd_idx = (state_q == ST_WAIT) ? addr_q[ADDR_W-1:2] : HADDR[ADDR_W-1:2];

  // Zero-wait reads sample the RAM on the same edge an earlier write commits.
  assign fwd_word = (commit && (addr_q[ADDR_W-1:2] == HADDR[ADDR_W-1:2]))
                  ? merge_lanes(rd_word, HWDATA, wr_be) : rd_word;

  assign unused_addr_hi = ^{HADDR[31:ADDR_W], HTRANS[0]};

  ahb_ram_byte_en #(
    .WORD_W (WORD_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_be),
    .waddr (addr_q[ADDR_W-1:2]),
    .wdata (HWDATA),
    .raddr (rd_idx),
    .rdata (rd_word)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    write_d     = write_q;
    size_d      = size_q;
    xfer_d      = 1'b0;
    hreadyout_d = 1'b1;
    hresp_d     = 1'b0;
    hrdata_d    = '0;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_IDLE;
          xfer_d  = 1'b1;
          if (!write_q) hrdata_d = rd_word;
        end else begin
          cnt_d       = cnt_q - 3'd1;
          hreadyout_d = 1'b0;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
        hresp_d = 1'b1;
      end
      default: begin
        // IDLE and ERR2 both complete a data phase, so a new address phase may ride along.
        state_d = ST_IDLE;
        if (accept) begin
          addr_d  = HADDR[ADDR_W-1:0];
          write_d = HWRITE;
          size_d  = HSIZE;
          if (!legal) begin
            state_d     = ST_ERR1;
            hreadyout_d = 1'b0;
            hresp_d     = 1'b1;
          end else if (WAIT_STATES == 0) begin
            xfer_d = 1'b1;
            if (!HWRITE) hrdata_d = fwd_word;
          end else begin
            state_d     = ST_WAIT;
            cnt_d       = 3'(WAIT_STATES - 1);
            hreadyout_d = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= 3'd0;
      xfer_q      <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      size_q      <= size_d;
      xfer_q      <= xfer_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Directed bench for ahb_ram_slave at WAIT_STATES 1, 0 and 2 with a byte-array reference
// memory and an in-flight transfer scoreboard.
module tb_ahb_ram_slave;
  import ahb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  hsel_v;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [2:0]  hrdy;
  logic [2:0]  hresp_v;
  logic [31:0] hrdata_v [3];
  logic [1:0]  act;
  logic        hready_bus;

  int n_cmp = 0;
  int n_bad = 0;
  int ws [3] = '{1, 0, 2};
  logic [7:0] mdl [3][1024];

  typedef struct {
    string       tag;
    logic        write;
    logic        legal;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] rdata;
    int          waits;
    logic        resp;
  } exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;

  assign hready_bus = hrdy[act];

  ahb_ram_slave #(.ADDR_W(10), .WAIT_STATES(1)) u_dut_w1 (
    .clk(clk), .reset(reset), .HSEL(hsel_v[0]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready_bus),
    .HREADYOUT(hrdy[0]), .HRESP(hresp_v[0]), .HRDATA(hrdata_v[0]));

  ahb_ram_slave #(.ADDR_W(10), .WAIT_STATES(0)) u_dut_w0 (
    .clk(clk), .reset(reset), .HSEL(hsel_v[1]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready_bus),
    .HREADYOUT(hrdy[1]), .HRESP(hresp_v[1]), .HRDATA(hrdata_v[1]));

  ahb_ram_slave #(.ADDR_W(10), .WAIT_STATES(2)) u_dut_w2 (
    .clk(clk), .reset(reset), .HSEL(hsel_v[2]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready_bus),
    .HREADYOUT(hrdy[2]), .HRESP(hresp_v[2]), .HRDATA(hrdata_v[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mdl_write(input logic [31:0] a, input logic [2:0] size, input logic [31:0] d);
    for (int i = 0; i < (1 << size); i++) begin
      int ba;
      int lane;
      ba   = int'((a + 32'(i)) & 32'h3FF);
      lane = int'((a + 32'(i)) & 32'h3);
      mdl[act][ba] = d[8*lane +: 8];
    end
  endtask

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    int w;
    w = int'(a & 32'h3FC);
    return {mdl[act][w+3], mdl[act][w+2], mdl[act][w+1], mdl[act][w]};
  endfunction

  // Drives one address phase (plus data for the transfer already in its data phase), waits for
  // the bus to accept it, checks the completing transfer and queues the new one.
  task automatic step(input string tag, input logic sel, input logic [1:0] trans,
                      input logic wr, input logic [2:0] size, input logic [31:0] addr,
                      input logic [31:0] wd_prev);
    int   waits;
    exp_t e;
    hsel_v = sel ? (3'b001 << act) : 3'b000;
    htrans = trans;
    hwrite = wr;
    hsize  = size;
    haddr  = addr;
    hwdata = wd_prev;
    waits  = 0;
    while (hready_bus !== 1'b1 && waits <= 16) begin
      if (sb.size() > 0) chk({sb[0].tag, "/wait_resp"}, 32'(hresp_v[act]), 32'(sb[0].resp));
      waits++;
      @(posedge clk);
      @(negedge clk);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "/waits"},  32'(waits), 32'(e.waits));
      chk({e.tag, "/hresp"},  32'(hresp_v[act]), 32'(e.resp));
      chk({e.tag, "/hrdata"}, hrdata_v[act], e.rdata);
      if (e.write && e.legal) mdl_write(e.addr, e.size, wd_prev);
    end else begin
      chk({tag, "/idle_waits"},  32'(waits), 32'd0);
      chk({tag, "/idle_hresp"},  32'(hresp_v[act]), 32'd0);
      chk({tag, "/idle_hrdata"}, hrdata_v[act], 32'd0);
    end
    if (sel && trans[1]) begin
      e.tag   = tag;
      e.write = wr;
      e.addr  = addr;
      e.size  = size;
      e.legal = (size <= 3'd2) && ((addr & ((32'd1 << size) - 32'd1)) == 32'd0);
      e.waits = e.legal ? ws[act] : 1;
      e.resp  = !e.legal;
      e.rdata = (e.legal && !wr) ? mdl_read(addr) : 32'h0;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_mid_wait(input string tag);
    chk({tag, "/in_wait"}, 32'(hready_bus), 32'd0);
    reset  = 1'b1;
    hsel_v = 3'b000;
    htrans = HTRANS_IDLE;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "/rst_hreadyout"}, 32'(hrdy[act]), 32'd1);
    chk({tag, "/rst_hresp"},     32'(hresp_v[act]), 32'd0);
    chk({tag, "/rst_hrdata"},    hrdata_v[act], 32'd0);
    reset = 1'b0;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of the sequence");
    $fatal(1, "timeout");
  end

  initial begin
    reset  = 1'b1;
    act    = 2'd0;
    hsel_v = 3'b000;
    haddr  = '0;
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
    hsize  = 3'd0;
    hwdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset%0d/hreadyout", i), 32'(hrdy[i]), 32'd1);
      chk($sformatf("reset%0d/hresp", i),     32'(hresp_v[i]), 32'd0);
      chk($sformatf("reset%0d/hrdata", i),    hrdata_v[i], 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    // One wait state: word, byte-lane, halfword, error, aliasing and BUSY cases.
    act = 2'd0;
    step("a_wr8",   1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h008, 32'h0);
    step("a_rd8",   1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h008, 32'h1234_5678);
    step("a_wrC",   1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h00C, 32'h0);
    step("a_wbD",   1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h00D, 32'h0000_0000);
    step("a_rdC",   1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h00C, 32'h0000_AB00);
    step("a_whE",   1, HTRANS_SEQ,    1, HSIZE_HALF, 32'h00E, 32'h0);
    step("a_rdC2",  1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h00C, 32'hBEEF_0000);
    step("a_wr0",   1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h000, 32'h0);
    step("a_bad1",  1, HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h001, 32'hA5A5_A5A5);
    step("a_rd0",   1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h000, 32'hFFFF_FFFF);
    step("a_badsz", 1, HTRANS_NONSEQ, 0, 3'b011,     32'h000, 32'h0);
    step("a_alias", 1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'hFFFF_F408, 32'h0);
    step("a_rdal",  1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h008, 32'h0BAD_F00D);
    step("a_wr20",  1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h020, 32'h0);
    step("a_busy",  1, HTRANS_BUSY,   1, HSIZE_WORD, 32'h020, 32'h5555_AAAA);
    step("a_rd20",  1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h020, 32'hFFFF_FFFF);
    step("a_end",   0, HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,   32'h0);
    step("a_idle",  0, HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,   32'h0);

    // Zero wait states: back-to-back write/read of the same word.
    act = 2'd1;
    step("b_wr10",  1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h010, 32'h0);
    step("b_rd10",  1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h010, 32'hCAFE_F00D);
    step("b_wb12",  1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h012, 32'h0);
    step("b_rd10b", 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h010, 32'h0077_0000);
    step("b_end",   0, HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,   32'h0);

    // Two wait states with reset pulsed inside a write and inside a read.
    act = 2'd2;
    step("c_wr40",  1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h040, 32'h0);
    step("c_rd40",  1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h040, 32'h1111_1111);
    step("c_end1",  0, HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,   32'h0);
    step("c_wrx",   1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h040, 32'h0);
    hwdata = 32'h2222_2222;
    reset_mid_wait("c_wrx");
    step("c_rdx",   1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h040, 32'h0);
    reset_mid_wait("c_rdx");
    step("c_wr44",  1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h044, 32'h0);
    step("c_rd40b", 1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h040, 32'h3333_3333);
    step("c_rd44",  1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h044, 32'h0);
    step("c_end2",  0, HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,   32'h0);
    step("c_idle",  0, HTRANS_IDLE,   0, HSIZE_WORD, 32'h0,   32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
